// File: rtl/if_network_sched.sv
// if_network_sched: timestep scheduler that runs one spike pattern through an integrate-and-fire network and counts output spikes
// Build option: define IF_NETWORK_SCHED_WINNER_EN to add the winner/winner_valid outputs and their comparator.
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   start, sample_in      host request and spike pattern, accepted only in IDLE
//   abort                 cancel the sample in CLEAR/RUN/DRAIN and return to IDLE
//   busy, done            high outside IDLE; one-cycle pulse when spike_count is final
//   net_rst               active-high network reset (IDLE, CLEAR, DONE)
//   net_spike_in          latched pattern during RUN, zero otherwise
//   net_spike_out         output neuron spikes from the network
//   spike_count           saturating per-neuron counts, neuron k at [k*CNT_WIDTH +: CNT_WIDTH]
//   step_idx              RUN step 1..NUM_STEPS, 0 outside RUN
//   winner, winner_valid  (option) lowest index holding the largest count; that count is nonzero
module if_network_sched #(
  parameter int NUM_INPUTS   = 4,
  parameter int NUM_OUTPUTS  = 1,
  parameter int NUM_STEPS    = 16,
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 8,
  localparam int SW = $clog2(NUM_STEPS + 1),
  localparam int WW = NUM_OUTPUTS > 1 ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_INPUTS-1:0]            sample_in,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  output logic                             net_rst,
  output logic [NUM_INPUTS-1:0]            net_spike_in,
  input  logic [NUM_OUTPUTS-1:0]           net_spike_out,
  output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] spike_count,
  output logic [SW-1:0]                    step_idx
`ifdef IF_NETWORK_SCHED_WINNER_EN
  ,
  output logic [WW-1:0]                    winner,
  output logic                             winner_valid
`endif
);
  localparam int MAXC = CLEAR_CYCLES > DRAIN_CYCLES ? CLEAR_CYCLES : DRAIN_CYCLES;
  localparam int PW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t                           state_q, state_d;
  logic [PW-1:0]                    cnt_q, cnt_d;
  logic [SW-1:0]                    step_q, step_d;
  logic [NUM_INPUTS-1:0]            sample_q, sample_d, spike_in_q;
  logic [NUM_OUTPUTS*CNT_WIDTH-1:0] count_q, count_d;
  logic                             done_q;
  logic                             counting;
  assign busy         = state_q != S_IDLE;
  assign net_rst      = state_q == S_IDLE || state_q == S_CLEAR || state_q == S_DONE;
  assign counting     = state_q == S_RUN || state_q == S_DRAIN;
  assign done         = done_q;
  assign net_spike_in = spike_in_q;
  assign spike_count  = count_q;
  assign step_idx     = step_q;
  // cnt_q times CLEAR and DRAIN; step_q doubles as the RUN timer and is zero elsewhere
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    step_d   = '0;
    sample_d = sample_q;
    count_d  = count_q;
    for (int k = 0; k < NUM_OUTPUTS; k++)
      if (counting && net_spike_out[k] && count_q[k*CNT_WIDTH +: CNT_WIDTH] != '1)
        count_d[k*CNT_WIDTH +: CNT_WIDTH] = count_q[k*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
    case (state_q)
      S_IDLE:
        if (start) begin
          state_d  = S_CLEAR;
          sample_d = sample_in;
          count_d  = '0;
        end
      S_CLEAR:
        if (cnt_q == PW'(CLEAR_CYCLES - 1)) begin
          state_d = S_RUN;
          step_d  = SW'(1);
        end else
          cnt_d = cnt_q + 1'b1;
      S_RUN:
        if (step_q == SW'(NUM_STEPS))
          state_d = DRAIN_CYCLES == 0 ? S_DONE : S_DRAIN;
        else
          step_d = step_q + 1'b1;
      S_DRAIN:
        if (cnt_q == PW'(DRAIN_CYCLES - 1))
          state_d = S_DONE;
        else
          cnt_d = cnt_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
    // abort wins over sequencing but keeps this cycle's count update
    if (abort && (counting || state_q == S_CLEAR)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      step_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      sample_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      spike_in_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      sample_q   <= sample_d;
      count_q    <= count_d;
      done_q     <= state_d == S_DONE;
      spike_in_q <= state_d == S_RUN ? sample_d : '0;
    end
  end
`ifdef IF_NETWORK_SCHED_WINNER_EN
  logic [WW-1:0]        win_d, winner_q;
  logic [CNT_WIDTH-1:0] best;
  logic                 winner_valid_q;
  // strict > keeps the lowest index on ties; evaluated on the final counts entering DONE
  always_comb begin
    win_d = '0;
    best  = count_d[CNT_WIDTH-1:0];
    for (int k = 1; k < NUM_OUTPUTS; k++)
      if (count_d[k*CNT_WIDTH +: CNT_WIDTH] > best) begin
        best  = count_d[k*CNT_WIDTH +: CNT_WIDTH];
        win_d = WW'(k);
      end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
    end else if (state_d == S_DONE) begin
      winner_q       <= win_d;
      winner_valid_q <= best != '0;
    end
  end
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
`endif
endmodule

// File: tb/tb_if_network_sched.sv
// tb_if_network_sched: directed bench for if_network_sched (default instance plus a 4-neuron, 4-bit-counter instance)
module tb_if_network_sched;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, so = 1'b0;
  logic [3:0]  sample_in = '0, so4 = '0;
  logic        busy, done, nrst, busy4, done4, nrst4;
  logic [3:0]  nsi, nsi4;
  logic [7:0]  cnt;
  logic [15:0] cnt4;
  logic [4:0]  sidx, sidx4;
`ifdef IF_NETWORK_SCHED_WINNER_EN
  logic        win, wv, wv4;
  logic [1:0]  win4;
`endif
  int n_cmp = 0, n_bad = 0, mode = 0;
  int tgt[4];

  always #5 clk = ~clk;

  if_network_sched dut (
    .clk(clk), .rst(rst), .start(start), .sample_in(sample_in), .abort(abort),
    .busy(busy), .done(done), .net_rst(nrst), .net_spike_in(nsi),
    .net_spike_out(so), .spike_count(cnt), .step_idx(sidx)
`ifdef IF_NETWORK_SCHED_WINNER_EN
    , .winner(win), .winner_valid(wv)
`endif
  );

  if_network_sched #(.NUM_OUTPUTS(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .sample_in(sample_in), .abort(abort),
    .busy(busy4), .done(done4), .net_rst(nrst4), .net_spike_in(nsi4),
    .net_spike_out(so4), .spike_count(cnt4), .step_idx(sidx4)
`ifdef IF_NETWORK_SCHED_WINNER_EN
    , .winner(win4), .winner_valid(wv4)
`endif
  );

  // Cycle j counts negedges after the cycle in which start was presented:
  // 1..2 CLEAR, 3..18 RUN, 19..21 DRAIN, 22 DONE. Drives network spikes for cycle j.
  task automatic cyc(input int j);
    @(negedge clk);
    so  = 1'b0;
    so4 = '0;
    if (mode == 1) begin
      so  = (j >= 3 && j <= 21);
      so4 = {3'b000, so};
    end else if (mode == 2) begin
      so  = !(j >= 3 && j <= 21);
      so4 = {4{so}};
    end else if (mode == 3)
      for (int k = 0; k < 4; k++) so4[k] = (j >= 3 && j - 3 < tgt[k]);
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #2;
    n_cmp++;
    if ({busy, done, nrst, nsi, sidx, cnt} !== {1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", {busy, done, nrst, nsi, sidx, cnt}, {1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 8'd0});
    end
    n_cmp++;
    if (cnt4 !== 16'h0) begin n_bad++; $display("FAIL reset_cnt4: got %h want 0000", cnt4); end
`ifdef IF_NETWORK_SCHED_WINNER_EN
    n_cmp++;
    if ({win, wv, win4, wv4} !== 5'b0) begin n_bad++; $display("FAIL reset_winner: got %b want 00000", {win, wv, win4, wv4}); end
`endif
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [11:0] want, got;
    mode = 0;
    cyc(0); start = 1'b1; sample_in = 4'b1010;
    for (int j = 1; j <= 23; j++) begin
      cyc(j);
      want = {(j >= 1 && j <= 22), (j == 22), (j <= 2 || j >= 22),
              (j >= 3 && j <= 18) ? 4'b1010 : 4'b0000,
              (j >= 3 && j <= 18) ? 5'(j - 2) : 5'd0};
      got = {busy, done, nrst, nsi, sidx};
      n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL basic_cycle%0d {busy,done,net_rst,spike_in,step}: got %h want %h", j, got, want); end
      start = (j == 5 || j == 22);
      sample_in = (j == 5) ? 4'b0101 : 4'b1010;
    end
    start = 1'b0;
  endtask

  task automatic test_count;
    mode = 1;
    cyc(0); start = 1'b1; sample_in = 4'b0110;
    for (int j = 1; j <= 22; j++) begin
      cyc(j);
      start = 1'b0;
    end
    n_cmp++;
    if ({done, cnt} !== {1'b1, 8'd19}) begin n_bad++; $display("FAIL count_run_drain: got done=%b cnt=%0d want done=1 cnt=19", done, cnt); end
    n_cmp++;
    if (cnt4 !== 16'h000F) begin n_bad++; $display("FAIL count_saturate: got %h want 000f", cnt4); end
`ifdef IF_NETWORK_SCHED_WINNER_EN
    n_cmp++;
    if ({win, wv, win4, wv4} !== {1'b0, 1'b1, 2'd0, 1'b1}) begin n_bad++; $display("FAIL winner_single: got %b want 01001", {win, wv, win4, wv4}); end
`endif
    mode = 2;
    cyc(0); start = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      cyc(j);
      start = 1'b0;
      if (j == 1) begin
        n_cmp++;
        if ({cnt, cnt4} !== 24'h0) begin n_bad++; $display("FAIL count_cleared_on_start: got %h want 000000", {cnt, cnt4}); end
      end
    end
    n_cmp++;
    if ({busy, cnt, cnt4} !== 25'h0) begin n_bad++; $display("FAIL count_idle_clear_only: got %h want 0", {busy, cnt, cnt4}); end
`ifdef IF_NETWORK_SCHED_WINNER_EN
    n_cmp++;
    if ({wv, wv4, win4} !== 4'b0) begin n_bad++; $display("FAIL winner_zero_counts: got %b want 0000", {wv, wv4, win4}); end
`endif
    mode = 0;
  endtask

  task automatic test_winner;
    tgt = '{3, 7, 7, 1};
    mode = 3;
    cyc(0); start = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      cyc(j);
      start = 1'b0;
      if (j == 22) begin
        n_cmp++;
        if ({done4, cnt4} !== {1'b1, 16'h1773}) begin n_bad++; $display("FAIL winner_counts: got done=%b cnt=%h want done=1 cnt=1773", done4, cnt4); end
      end
`ifdef IF_NETWORK_SCHED_WINNER_EN
      if (j >= 22) begin
        n_cmp++;
        if ({win4, wv4} !== {2'd1, 1'b1}) begin n_bad++; $display("FAIL winner_tie_cycle%0d: got win=%0d valid=%b want win=1 valid=1", j, win4, wv4); end
      end
`endif
    end
    mode = 0;
  endtask

  task automatic test_abort;
    mode = 1;
    cyc(0); start = 1'b1; abort = 1'b1; sample_in = 4'b0011;
    cyc(1);
    n_cmp++;
    if ({busy, nrst, cnt, cnt4} !== {1'b1, 1'b1, 8'd0, 16'h0}) begin n_bad++; $display("FAIL abort_with_start_idle: got %h want %h", {busy, nrst, cnt, cnt4}, {1'b1, 1'b1, 8'd0, 16'h0}); end
`ifdef IF_NETWORK_SCHED_WINNER_EN
    n_cmp++;
    if ({win4, wv4} !== 3'b0) begin n_bad++; $display("FAIL winner_cleared_on_start: got %b want 000", {win4, wv4}); end
`endif
    start = 1'b0; abort = 1'b0;
    for (int j = 2; j <= 7; j++) cyc(j);
    n_cmp++;
    if (sidx !== 5'd5) begin n_bad++; $display("FAIL abort_step: got %0d want 5", sidx); end
    abort = 1'b1;
    cyc(8);
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, nrst, nsi, sidx} !== {1'b0, 1'b0, 1'b1, 4'h0, 5'd0}) begin n_bad++; $display("FAIL abort_idle: got %h want %h", {busy, done, nrst, nsi, sidx}, {1'b0, 1'b0, 1'b1, 4'h0, 5'd0}); end
    n_cmp++;
    if ({cnt, cnt4} !== {8'd5, 16'h0005}) begin n_bad++; $display("FAIL abort_partial: got %h want 050005", {cnt, cnt4}); end
    for (int j = 9; j <= 30; j++) begin
      cyc(j);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL abort_no_done_cycle%0d: got busy,done=%b want 00", j, {busy, done}); end
    end
    mode = 0;
    cyc(0); start = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      cyc(j);
      start = 1'b0;
      if (j == 1) begin
        n_cmp++;
        if ({cnt, cnt4} !== 24'h0) begin n_bad++; $display("FAIL abort_restart_clear: got %h want 000000", {cnt, cnt4}); end
      end
    end
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL abort_restart_done: got %b want 1", done); end
  endtask

  task automatic test_reset_mid;
    mode = 1;
    cyc(0); start = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cyc(j);
      start = 1'b0;
    end
    n_cmp++;
    if ({sidx, cnt} !== {5'd8, 8'd7}) begin n_bad++; $display("FAIL midrun_state: got step=%0d cnt=%0d want step=8 cnt=7", sidx, cnt); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, nrst, nsi, sidx, cnt, cnt4} !== {1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 8'd0, 16'h0}) begin
      n_bad++;
      $display("FAIL midrun_async_reset: got %h want %h", {busy, done, nrst, nsi, sidx, cnt, cnt4}, {1'b0, 1'b0, 1'b1, 4'h0, 5'd0, 8'd0, 16'h0});
    end
    mode = 0;
    @(negedge clk) rst = 1'b1;
    cyc(1);
    n_cmp++;
    if ({busy, nrst, nsi} !== {1'b0, 1'b1, 4'h0}) begin n_bad++; $display("FAIL after_reset_idle: got %h want %h", {busy, nrst, nsi}, {1'b0, 1'b1, 4'h0}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_count;
    test_winner;
    test_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
